pkc_coeff_source: RTL

Parametrised, synthesizable coefficient source for the Ring-LWE PKC datapath. It supplies per-channel streams of N polynomial coefficients to the KeyGen and Enc sample inputs. Each channel runs in one of two modes: uniform mod p (rejection-sampled, for `a`) or small bounded error (windowed, for s, e, r0, r1, r2). It replaces free-running bench randomness with a deterministic, seedable, backpressure-aware handshake source. The same block serves simulation and FPGA bring-up.

---
 rtl/pkc_src_pkg.sv | 34 +++
 rtl/pkc_coeff_source_if.sv | 28 ++
 rtl/pkc_src_channel.sv | 129 ++++++++++++
 rtl/pkc_coeff_source.sv | 47 ++++
 4 files changed

// File: rtl/pkc_src_pkg.sv
// Shared types and helpers for the PKC coefficient source.
// Holds the channel state encoding, mode constants, PRNG step and seed derivation.
// Pure declarations; no logic, no latency, no backpressure.
package pkc_src_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        VALID = 2'd2
    } state_e;

    localparam logic MODE_UNIFORM = 1'b0;
    localparam logic MODE_SMALL   = 1'b1;

    // Golden-ratio increment spreads per-channel seeds across the 32-bit space.
    localparam logic [31:0] SEED_INC = 32'h9E3779B9;

    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    // An all-zero state would lock xorshift at zero forever, so it is remapped to 1.
    function automatic logic [31:0] chan_seed(input logic [31:0] base, input int unsigned c);
        logic [31:0] s;
        s = base + SEED_INC * c;
        if (s == 32'h0) s = 32'h1;
        return s;
    endfunction

endpackage

// File: rtl/pkc_coeff_source_if.sv
// Handshake bundle between the coefficient source and its consumers.
// Wires only; no latency.
// Consumer drives coeff_ready per channel; the source holds data while it is low.
interface pkc_coeff_source_if #(
    parameter int NUM_CH = 2,
    parameter int LOGP   = 21,
    parameter int LOGN   = 8
);
    logic [NUM_CH-1:0]      start;
    logic [NUM_CH-1:0]      mode;
    logic [NUM_CH-1:0]      coeff_ready;
    logic [NUM_CH-1:0]      coeff_valid;
    logic [NUM_CH*LOGP-1:0] coeff;
    logic [NUM_CH*LOGN-1:0] coeff_idx;
    logic [NUM_CH-1:0]      coeff_last;
    logic [NUM_CH-1:0]      busy;
    logic [NUM_CH-1:0]      done;

    modport master (
        input  start, mode, coeff_ready,
        output coeff_valid, coeff, coeff_idx, coeff_last, busy, done
    );

    modport slave (
        output start, mode, coeff_ready,
        input  coeff_valid, coeff, coeff_idx, coeff_last, busy, done
    );
endinterface

// File: rtl/pkc_src_channel.sv
// One coefficient channel: xorshift PRNG, uniform/small sampler and IDLE/DRAW/VALID FSM.
// start->busy 1 cycle, ->valid 2 cycles (+1 per uniform rejection); transfer->next valid 2 cycles.
// Data, index and last are held stable while coeff_ready is low. Macro: PKC_SRC_SIGNED_ERR_EN.
module pkc_src_channel
    import pkc_src_pkg::*;
#(
    parameter int          P         = 1049089,
    parameter int          N         = 256,
    parameter int          LOGP      = $clog2(P),
    parameter int          LOGN      = $clog2(N),
    parameter int          ERR_BOUND = 8,
    parameter int          WINDOW    = N,
    parameter logic [31:0] SEED      = 32'h1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            mode,
    input  logic            coeff_ready,
    output logic            coeff_valid,
    output logic [LOGP-1:0] coeff,
    output logic [LOGN-1:0] coeff_idx,
    output logic            coeff_last,
    output logic            busy,
    output logic            done
);
    localparam int ERR_LOG = $clog2(ERR_BOUND);

    state_e          state_q, state_d;
    logic            mode_q, mode_d;
    logic [LOGN-1:0] idx_q, idx_d;
    logic [LOGP-1:0] coeff_q, coeff_d;
    logic            done_q, done_d;
    logic [31:0]     prng_q, prng_d;

    logic [LOGP-1:0]    uni_cand;
    logic               uni_ok;
    logic [ERR_LOG-1:0] err_mag;
    logic [LOGP-1:0]    small_val;
    logic               at_last;

    // Sampler: candidate values derived from the current PRNG word.
    always_comb begin
        uni_cand  = prng_q[LOGP-1:0];
        uni_ok    = (32'(uni_cand) < 32'(P));
        err_mag   = prng_q[ERR_LOG-1:0];
        small_val = '0;
        if (32'(idx_q) < 32'(WINDOW)) begin
            small_val = LOGP'(err_mag);
`ifdef PKC_SRC_SIGNED_ERR_EN
            // Negative magnitude maps to P-v; negative zero stays 0.
            if (prng_q[ERR_LOG] && (err_mag != '0)) begin
                small_val = LOGP'(P) - LOGP'(err_mag);
            end
`endif
        end
    end

    // State register: FSM, index, held coefficient, done pulse and PRNG.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= MODE_UNIFORM;
            idx_q   <= '0;
            coeff_q <= '0;
            done_q  <= 1'b0;
            prng_q  <= SEED;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            coeff_q <= coeff_d;
            done_q  <= done_d;
            prng_q  <= prng_d;
        end
    end

    // Next state: PRNG free-runs every cycle regardless of FSM state.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        coeff_d = coeff_q;
        done_d  = 1'b0;
        prng_d  = xorshift32(prng_q);
        at_last = (idx_q == LOGN'(N - 1));
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    idx_d   = '0;
                    state_d = DRAW;
                end
            end
            DRAW: begin
                if (mode_q == MODE_SMALL) begin
                    coeff_d = small_val;
                    state_d = VALID;
                end else if (uni_ok) begin
                    coeff_d = uni_cand;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (coeff_ready) begin
                    if (at_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = DRAW;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: all derived from registered state.
    always_comb begin
        coeff_valid = (state_q == VALID);
        coeff       = coeff_q;
        coeff_idx   = idx_q;
        coeff_last  = (state_q == VALID) && (idx_q == LOGN'(N - 1));
        busy        = (state_q != IDLE);
        done        = done_q;
    end

endmodule

// File: rtl/pkc_coeff_source.sv
// Multi-channel coefficient source for Ring-LWE KeyGen/Enc; channels are independent.
// Per channel: start->valid 2 cycles (+rejections); peak 1 coefficient per 2 cycles.
// Each channel stalls on its own coeff_ready. Macro: PKC_SRC_SIGNED_ERR_EN (signed small errors).
module pkc_coeff_source
    import pkc_src_pkg::*;
#(
    parameter int          P         = 1049089,
    parameter int          N         = 256,
    parameter int          LOGP      = $clog2(P),
    parameter int          LOGN      = $clog2(N),
    parameter int          NUM_CH    = 2,
    parameter int          ERR_BOUND = 8,
    parameter int          WINDOW    = N,
    parameter logic [31:0] SEED      = 32'h1
) (
    input  logic clk,
    input  logic reset,
    pkc_coeff_source_if.master bus
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [31:0] CH_SEED = chan_seed(SEED, c);

        pkc_src_channel #(
            .P         (P),
            .N         (N),
            .LOGP      (LOGP),
            .LOGN      (LOGN),
            .ERR_BOUND (ERR_BOUND),
            .WINDOW    (WINDOW),
            .SEED      (CH_SEED)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .start       (bus.start[c]),
            .mode        (bus.mode[c]),
            .coeff_ready (bus.coeff_ready[c]),
            .coeff_valid (bus.coeff_valid[c]),
            .coeff       (bus.coeff[c*LOGP +: LOGP]),
            .coeff_idx   (bus.coeff_idx[c*LOGN +: LOGN]),
            .coeff_last  (bus.coeff_last[c]),
            .busy        (bus.busy[c]),
            .done        (bus.done[c])
        );
    end

endmodule
